// File: rtl/bp_fe_cmd_scheduler_pkg.sv
// rtl/bp_fe_cmd_scheduler_pkg.sv - shared FE/BE command types and scheduler state encoding
package bp_fe_cmd_scheduler_pkg;

    localparam int bp_vaddr_width_gp = 39;

    typedef enum logic [2:0] {
        e_op_state_reset          = 3'd0,
        e_op_pc_redirection       = 3'd1,
        e_op_icache_fill_response = 3'd2
    } bp_fe_command_queue_opcode_e;

    typedef enum logic [1:0] {
        e_reset,
        e_boot,
        e_run,
        e_drain
    } bp_fe_sched_state_e;

    typedef struct packed {
        bp_fe_command_queue_opcode_e   opcode;
        logic [bp_vaddr_width_gp-1:0]  vaddr;
    } bp_fe_cmd_s;

    // Grant vector bit positions shared by the arbiter and the top.
    localparam int gnt_redirect_lp = 0;
    localparam int gnt_fill_lp     = 1;

endpackage

// File: rtl/bp_fe_cmd_scheduler_if.sv
// rtl/bp_fe_cmd_scheduler_if.sv - redirect, fill and FE command channels of the scheduler
interface bp_fe_cmd_scheduler_if #(
    parameter int vaddr_width_p = 39
);
    logic                     redirect_v_i;
    logic [vaddr_width_p-1:0] redirect_vaddr_i;
    logic                     redirect_ready_o;
    logic                     fill_v_i;
    logic [vaddr_width_p-1:0] fill_vaddr_i;
    logic                     fill_ready_o;
    logic [2:0]               fe_cmd_opcode_o;
    logic [vaddr_width_p-1:0] fe_cmd_vaddr_o;
    logic                     fe_cmd_v_o;
    logic                     fe_cmd_yumi_i;

    modport master (
        output redirect_v_i, redirect_vaddr_i, fill_v_i, fill_vaddr_i, fe_cmd_yumi_i,
        input  redirect_ready_o, fill_ready_o, fe_cmd_opcode_o, fe_cmd_vaddr_o, fe_cmd_v_o
    );

    modport slave (
        input  redirect_v_i, redirect_vaddr_i, fill_v_i, fill_vaddr_i, fe_cmd_yumi_i,
        output redirect_ready_o, fill_ready_o, fe_cmd_opcode_o, fe_cmd_vaddr_o, fe_cmd_v_o
    );
endinterface

// File: rtl/bp_fe_cmd_arb.sv
// rtl/bp_fe_cmd_arb.sv - two-input fixed-priority arbiter with starvation override for the fill requester
module bp_fe_cmd_arb
    import bp_fe_cmd_scheduler_pkg::*;
#(
    parameter int starve_limit_p = 4
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
    localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

    logic [cnt_width_lp-1:0] starve_cnt_q, starve_cnt_d;
    logic                    both_req;
    logic                    starved;

    always_comb begin
        both_req = req_i[gnt_redirect_lp] & req_i[gnt_fill_lp];
        starved  = both_req && (starve_cnt_q == limit_lp);

        grant_o = '0;
        if (en_i) begin
            if (req_i[gnt_redirect_lp] && !starved) begin
                grant_o[gnt_redirect_lp] = 1'b1;
            end else if (req_i[gnt_fill_lp]) begin
                grant_o[gnt_fill_lp] = 1'b1;
            end
        end

        // Counts only lost fill arbitrations; any gap in fill_v restarts the count.
        starve_cnt_d = starve_cnt_q;
        if (!req_i[gnt_fill_lp] || grant_o[gnt_fill_lp]) begin
            starve_cnt_d = '0;
        end else if (both_req && grant_o[gnt_redirect_lp] && (starve_cnt_q != limit_lp)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/bp_fe_cmd_scheduler.sv
// rtl/bp_fe_cmd_scheduler.sv - FE command channel owner: boot sequencing, arbitration and one-entry command register
module bp_fe_cmd_scheduler
    import bp_fe_cmd_scheduler_pkg::*;
#(
    parameter int                       vaddr_width_p  = bp_vaddr_width_gp,
    parameter logic [vaddr_width_p-1:0] start_pc_p     = 39'h00_8000_0000,
    parameter int                       starve_limit_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   reboot_i,
    output logic                   queue_flush_o,
    output logic                   booted_o,
    bp_fe_cmd_scheduler_if.slave   cmd_if
);

    bp_fe_sched_state_e state_q, state_d;
    bp_fe_cmd_s         cmd_q, cmd_d;
    logic               cmd_v_q, cmd_v_d;
    logic               slot_free;
    logic               arb_en;
    logic [1:0]         grant;

    assign slot_free = ~cmd_v_q | cmd_if.fe_cmd_yumi_i;
    assign arb_en    = (state_q == e_run) & slot_free;

    bp_fe_cmd_arb #(
        .starve_limit_p (starve_limit_p)
    ) u_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .en_i      (arb_en),
        .req_i     ({cmd_if.fill_v_i, cmd_if.redirect_v_i}),
        .grant_o   (grant)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cmd_v_d = cmd_v_q & ~cmd_if.fe_cmd_yumi_i;

        case (state_q)
            e_reset: state_d = e_boot;
            e_boot: begin
                if (!cmd_v_q) begin
                    cmd_v_d      = 1'b1;
                    cmd_d.opcode = e_op_state_reset;
                    cmd_d.vaddr  = start_pc_p;
                end else if (cmd_if.fe_cmd_yumi_i) begin
                    state_d = e_run;
                end
            end
            e_run: begin
                if (grant[gnt_redirect_lp]) begin
                    cmd_v_d      = 1'b1;
                    cmd_d.opcode = e_op_pc_redirection;
                    cmd_d.vaddr  = cmd_if.redirect_vaddr_i;
                end else if (grant[gnt_fill_lp]) begin
                    cmd_v_d      = 1'b1;
                    cmd_d.opcode = e_op_icache_fill_response;
                    cmd_d.vaddr  = cmd_if.fill_vaddr_i;
                end
                if (reboot_i) begin
                    state_d = e_drain;
                end
            end
            e_drain: begin
                if (!cmd_v_q || cmd_if.fe_cmd_yumi_i) begin
                    state_d = e_boot;
                end
            end
            default: state_d = e_reset;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_reset;
            cmd_q   <= '0;
            cmd_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cmd_v_q <= cmd_v_d;
        end
    end

    assign cmd_if.redirect_ready_o = grant[gnt_redirect_lp];
    assign cmd_if.fill_ready_o     = grant[gnt_fill_lp];
    assign cmd_if.fe_cmd_opcode_o  = cmd_q.opcode;
    assign cmd_if.fe_cmd_vaddr_o   = cmd_q.vaddr;
    assign cmd_if.fe_cmd_v_o       = cmd_v_q;
    assign queue_flush_o           = cmd_v_q;
    assign booted_o                = (state_q == e_run);

endmodule

// File: tb/tb_bp_fe_cmd_scheduler.sv
// tb/tb_bp_fe_cmd_scheduler.sv - scoreboard bench for bp_fe_cmd_scheduler
module tb_bp_fe_cmd_scheduler;

    localparam logic [38:0] start_pc_lp = 39'h00_8000_0000;

    logic clk = 1'b0;
    logic reset_n;
    logic reboot;
    logic queue_flush;
    logic booted;
    logic yumi_en;

    int n_tests = 0;
    int n_fail  = 0;

    logic [41:0] exp_q[$];

    bp_fe_cmd_scheduler_if #(.vaddr_width_p(39)) bus ();

    bp_fe_cmd_scheduler dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .reboot_i      (reboot),
        .queue_flush_o (queue_flush),
        .booted_o      (booted),
        .cmd_if        (bus)
    );

    always #5 clk = ~clk;

    // The FE model only consumes when a command is actually presented.
    assign bus.fe_cmd_yumi_i = yumi_en & bus.fe_cmd_v_o;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [38:0] r_va(input int i);
        return 39'h10000 + 39'(i * 4);
    endfunction

    function automatic logic [38:0] f_va(input int i);
        return 39'h20000 + 39'(i * 64);
    endfunction

    function automatic logic [41:0] mk(input logic [2:0] op, input logic [38:0] va);
        return {op, va};
    endfunction

    always @(negedge clk) begin
        if (reset_n && bus.fe_cmd_v_o && bus.fe_cmd_yumi_i) begin
            if (exp_q.size() == 0) begin
                chk("cmd_unexpected", {22'd0, bus.fe_cmd_opcode_o, bus.fe_cmd_vaddr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("cmd", {22'd0, bus.fe_cmd_opcode_o, bus.fe_cmd_vaddr_o}, {22'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        int rcnt;
        int fcnt;
        int rp;
        int fp;
        bit exp_fill;
        bit seen;

        reset_n              = 1'b0;
        reboot               = 1'b0;
        yumi_en              = 1'b0;
        bus.redirect_v_i     = 1'b1;
        bus.redirect_vaddr_i = 39'h1000;
        bus.fill_v_i         = 1'b1;
        bus.fill_vaddr_i     = 39'h2040;

        repeat (3) tick();
        chk("rst_cmd_v", bus.fe_cmd_v_o, 0);
        chk("rst_flush", queue_flush, 0);
        chk("rst_booted", booted, 0);
        chk("rst_opcode", bus.fe_cmd_opcode_o, 0);
        chk("rst_vaddr", bus.fe_cmd_vaddr_o, 0);
        chk("rst_rdy_r", bus.redirect_ready_o, 0);
        chk("rst_rdy_f", bus.fill_ready_o, 0);

        // Boot with the FE stalled; both requesters already waiting.
        reset_n = 1'b1;
        exp_q.push_back(mk(3'd0, start_pc_lp));
        exp_q.push_back(mk(3'd1, 39'h1000));
        exp_q.push_back(mk(3'd2, 39'h2040));
        repeat (5) tick();
        chk("boot_v", bus.fe_cmd_v_o, 1);
        chk("boot_opcode", bus.fe_cmd_opcode_o, 0);
        chk("boot_vaddr", bus.fe_cmd_vaddr_o, {25'd0, start_pc_lp});
        chk("boot_flush", queue_flush, 1);
        chk("boot_booted", booted, 0);
        chk("boot_rdy_r", bus.redirect_ready_o, 0);
        chk("boot_rdy_f", bus.fill_ready_o, 0);
        yumi_en = 1'b1;
        #1;
        chk("boot_yumi_rdy_r", bus.redirect_ready_o, 0);
        tick();
        chk("boot_done", booted, 1);

        // Priority: redirect first, fill one cycle later.
        chk("prio_rdy_r", bus.redirect_ready_o, 1);
        chk("prio_rdy_f", bus.fill_ready_o, 0);
        tick();
        bus.redirect_v_i = 1'b0;
        #1;
        chk("prio_fill_rdy", bus.fill_ready_o, 1);
        tick();

        // Starvation: 4 redirects then 1 fill, repeating.
        rp = 0;
        fp = 0;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) exp_q.push_back(mk(3'd2, f_va(fp++)));
            else            exp_q.push_back(mk(3'd1, r_va(rp++)));
        end
        rcnt = 0;
        fcnt = 0;
        bus.redirect_v_i     = 1'b1;
        bus.redirect_vaddr_i = r_va(0);
        bus.fill_v_i         = 1'b1;
        bus.fill_vaddr_i     = f_va(0);
        for (int k = 0; k < 10; k++) begin
            #1;
            exp_fill = (k % 5 == 4);
            chk("starve_rdy_r", bus.redirect_ready_o, {63'd0, !exp_fill});
            chk("starve_rdy_f", bus.fill_ready_o, {63'd0, exp_fill});
            tick();
            if (exp_fill) bus.fill_vaddr_i = f_va(++fcnt);
            else          bus.redirect_vaddr_i = r_va(++rcnt);
        end

        // Backpressure with the last fill held.
        yumi_en              = 1'b0;
        bus.redirect_vaddr_i = 39'h5000;
        bus.fill_vaddr_i     = 39'h6000;
        exp_q.push_back(mk(3'd1, 39'h5000));
        exp_q.push_back(mk(3'd2, 39'h6000));
        repeat (3) tick();
        chk("bp_v", bus.fe_cmd_v_o, 1);
        chk("bp_opcode", bus.fe_cmd_opcode_o, 2);
        chk("bp_vaddr", bus.fe_cmd_vaddr_o, {25'd0, f_va(1)});
        chk("bp_flush", queue_flush, 1);
        chk("bp_rdy_r", bus.redirect_ready_o, 0);
        chk("bp_rdy_f", bus.fill_ready_o, 0);
        yumi_en = 1'b1;
        #1;
        chk("bp_yumi_rdy_r", bus.redirect_ready_o, 1);
        tick();
        chk("bp_nobubble_v", bus.fe_cmd_v_o, 1);
        chk("bp_nobubble_vaddr", bus.fe_cmd_vaddr_o, 39'h5000);
        bus.redirect_v_i = 1'b0;
        #1;
        chk("bp_fill_rdy", bus.fill_ready_o, 1);
        tick();
        bus.fill_v_i = 1'b0;
        tick();

        // Reboot while a redirect is held.
        yumi_en              = 1'b0;
        bus.redirect_v_i     = 1'b1;
        bus.redirect_vaddr_i = 39'h7000;
        exp_q.push_back(mk(3'd1, 39'h7000));
        #1;
        chk("rb_pre_rdy_r", bus.redirect_ready_o, 1);
        tick();
        bus.redirect_vaddr_i = 39'h8000;
        reboot = 1'b1;
        tick();
        reboot = 1'b0;
        exp_q.push_back(mk(3'd0, start_pc_lp));
        exp_q.push_back(mk(3'd1, 39'h8000));
        repeat (2) tick();
        chk("rb_rdy_r", bus.redirect_ready_o, 0);
        chk("rb_booted", booted, 0);
        chk("rb_held_vaddr", bus.fe_cmd_vaddr_o, 39'h7000);
        yumi_en = 1'b1;
        #1;
        chk("rb_drain_rdy_r", bus.redirect_ready_o, 0);
        tick();
        chk("rb_boot_booted", booted, 0);
        chk("rb_boot_rdy_r", bus.redirect_ready_o, 0);
        tick();
        chk("rb_sr_opcode", bus.fe_cmd_opcode_o, 0);
        chk("rb_sr_vaddr", bus.fe_cmd_vaddr_o, {25'd0, start_pc_lp});
        chk("rb_sr_booted", booted, 0);
        tick();
        chk("rb_rebooted", booted, 1);
        chk("rb_run_rdy_r", bus.redirect_ready_o, 1);
        tick();
        bus.redirect_v_i = 1'b0;
        tick();

        // Async reset mid-cycle discards a held command.
        yumi_en              = 1'b0;
        bus.redirect_v_i     = 1'b1;
        bus.redirect_vaddr_i = 39'h9000;
        tick();
        bus.redirect_v_i = 1'b0;
        chk("ar_held_v", bus.fe_cmd_v_o, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_v", bus.fe_cmd_v_o, 0);
        chk("ar_flush", queue_flush, 0);
        chk("ar_booted", booted, 0);
        repeat (2) tick();
        reset_n = 1'b1;
        exp_q.push_back(mk(3'd0, start_pc_lp));
        yumi_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = booted;
        end
        chk("ar_reboot_timeout", {63'd0, seen}, 1);
        repeat (2) tick();
        chk("exp_q_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_fe_cmd_scheduler.md
Name: bp_fe_cmd_scheduler

Overview:
Back-end-side controller that owns the single FE command channel. It sequences the boot state-reset command, then arbitrates between two requesters for the channel: PC redirection (mispredict/trap) and icache fill response. It holds each command in a one-entry output register. While a command is outstanding it asserts a queue-flush so the FE queue input FIFO stays closed.

Parameters:
vaddr_width_p, 39, virtual address width of every vaddr field
start_pc_p, 39'h00_8000_0000, PC carried by the boot state-reset command
starve_limit_p, 4, consecutive lost arbitrations after which the fill requester is force-granted

Ports:
clk_i  in  1  clock; all state updates on the rising edge
reset_n_i  in  1  asynchronous, active-low reset
reboot_i  in  1  one-cycle pulse: drain, then re-issue state reset
redirect_v_i  in  1  redirect request valid
redirect_vaddr_i  in  vaddr_width_p  redirect target
redirect_ready_o  out  1  redirect accepted when v&ready
fill_v_i  in  1  icache fill response request valid
fill_vaddr_i  in  vaddr_width_p  missed vaddr being answered
fill_ready_o  out  1  fill accepted when v&ready
fe_cmd_opcode_o  out  3  bp_fe_command_queue_opcode_e (state_reset=0, pc_redirection=1, icache_fill_response=2)
fe_cmd_vaddr_o  out  vaddr_width_p  command vaddr
fe_cmd_v_o  out  1  command valid
fe_cmd_yumi_i  in  1  FE consumes command; only legal when fe_cmd_v_o=1
queue_flush_o  out  1  command outstanding; hold FE queue FIFO in reset
booted_o  out  1  high in e_run

Behaviour:
- Reset (reset_n_i=0, any cycle, including mid-command): state=e_reset, cmd_v_r=0, starve_cnt=0. All outputs are 0 and the held command is discarded.
- FSM:
  - e_reset: go to e_boot next cycle.
  - e_boot: load the output register with {state_reset, start_pc_p} if it is empty, then wait for yumi; on yumi go to e_run.
  - e_run: arbitrate. On reboot_i go to e_drain.
  - e_drain: no grants; when cmd_v_r=0 (or yumi this cycle) go to e_boot.
- reboot_i is ignored outside e_run.
- Output register: fe_cmd_v_o=cmd_v_r, and opcode/vaddr come straight from flops.
  - slot_free = ~cmd_v_r | fe_cmd_yumi_i. This is a combinational path from yumi to the ready outputs.
  - cmd_v_r is cleared on yumi unless it is reloaded in the same cycle.
- Grant (e_run & slot_free only; ready_o=0 otherwise):
  - Only one requester is granted per cycle.
  - Default priority: redirect > fill.
  - If fill_v_i & redirect_v_i & starve_cnt==starve_limit_p, grant fill instead.
- starve_cnt (width $clog2(starve_limit_p+1)):
  - +1 when both are valid, slot_free, and redirect is granted.
  - Cleared when fill is granted or fill_v_i=0.
  - Saturates at starve_limit_p.
- Granted request loads the register next edge: {pc_redirection, redirect_vaddr_i} or {icache_fill_response, fill_vaddr_i}.
- Latency: request accepted in cycle N appears on fe_cmd_v_o in cycle N+1. With yumi held high, throughput is one command per cycle.
- queue_flush_o = cmd_v_r.
- booted_o = (state==e_run).
- Requesters must hold v/vaddr stable until accepted; the scheduler never drops an accepted request.

Decomposition:
- Opcode enum and the state enum {e_reset,e_boot,e_run,e_drain} live in the shared FE/BE interface package alongside the fe_cmd struct.
- The 2-input fixed-priority-with-starvation-override arbiter is a natural sub-module: bp_fe_cmd_arb. Inputs: 2 requests, an enable, starve_limit_p. Outputs: one-hot grant, with the counter kept internal.
- The output register and FSM stay in the top module.

Test Plan:
- Boot: release reset_n_i, yumi tied 0 for 5 cycles.
  - Response: fe_cmd_v_o=1, opcode=0, vaddr=39'h0080000000 held stable; queue_flush_o=1; ready outputs=0.
  - Then yumi=1: booted_o=1 the next cycle.
- Priority: redirect_v=1 (vaddr 39'h1000) and fill_v=1 (vaddr 39'h2040) in the same cycle, yumi=1.
  - Response: the redirect command (opcode 1, 39'h1000) is issued first, then fill (opcode 2, 39'h2040) one cycle later.
- Starvation: fill_v=1 held continuously, redirect_v=1 with a new vaddr each cycle, yumi=1, starve_limit_p=4.
  - Response: exactly 4 redirects are issued, then 1 fill, then the pattern repeats.
- Backpressure: yumi=0 with a command held.
  - Response: both ready outputs=0, the command stays unchanged, queue_flush_o=1.
  - Then yumi=1 while redirect_v=1: the new command is loaded the next cycle with no bubble.
- Reboot: pulse reboot_i while a redirect is held and yumi=0.
  - Response: no new grants are made.
  - After yumi, a state_reset (opcode 0, start_pc_p) is issued and booted_o drops until it is consumed.
- Async reset: assert reset_n_i mid-cycle while a command is held.
  - Response: fe_cmd_v_o and queue_flush_o drop immediately, without waiting for a clock edge.
  - After release, the boot sequence repeats.
